ibex_cheri_cap_lsu: RTL and testbench
=====================================

Name: ibex_cheri_cap_lsu

Overview:
- Load/store unit directly downstream of the execute block; consumes the 32-bit ALU adder result as the effective address.
- Performs byte, halfword and word accesses.
- Performs tagged capability accesses: 64-bit compressed capability plus 1-bit tag, moved as two 32-bit bus beats with a tag sideband.
- Drives the Ibex-style req/gnt/rvalid data bus and returns load data and a completion pulse to the ID/WB path.

Parameters:
- CAP_MEM_W, 64, compressed in-memory capability width; fixed at 2 x 32.
- CHECK_CAP_ALIGN, 1, when 1, capability accesses must be 8-byte aligned.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- lsu_req_i  in  1  request new access; sampled only in IDLE
- lsu_we_i  in  1  1=store, 0=load
- lsu_cap_i  in  1  capability access; overrides lsu_type_i
- lsu_type_i  in  2  00 word, 01 half, 10 byte, 11 reserved (treated as word)
- lsu_sign_ext_i  in  1  sign-extend byte/half loads
- lsu_addr_i  in  32  effective address from EX adder
- lsu_wdata_i  in  32  store data (non-cap)
- lsu_cap_wdata_i  in  64  compressed capability to store
- lsu_cap_wtag_i  in  1  tag of stored capability
- lsu_rdata_o  out  32  aligned, extended load data
- lsu_cap_rdata_o  out  64  loaded capability
- lsu_cap_rtag_o  out  1  loaded tag
- lsu_valid_o  out  1  one-cycle completion pulse
- lsu_err_o  out  1  bus error, qualified by lsu_valid_o
- lsu_misaligned_o  out  1  alignment fault, qualified by lsu_valid_o
- lsu_busy_o  out  1  not in IDLE
- data_req_o  out  1  bus request
- data_gnt_i  in  1  bus grant
- data_rvalid_i  in  1  response valid
- data_err_i  in  1  response error
- data_addr_o  out  32  word-aligned bus address
- data_we_o  out  1  bus write
- data_be_o  out  4  byte enables
- data_wdata_o  out  32  bus write data, lane-shifted
- data_wtag_o  out  1  tag sideband for the write
- data_rdata_i  in  32  bus read data
- data_rtag_i  in  1  tag sideband for the read

Behaviour:
- Clock/reset: single clock domain; asynchronous active-low reset on rst_ni.
- Reset state: FSM=IDLE. All outputs 0: data_req_o, lsu_valid_o, lsu_err_o, lsu_misaligned_o, lsu_busy_o, data_* outputs, lsu_rdata_o, lsu_cap_rdata_o, lsu_cap_rtag_o. Reset mid-transaction abandons the access with no completion pulse; late rvalid after reset is ignored.
- FSM states: IDLE, GNT0, RVALID0, GNT1, RVALID1, FAULT.
- Acceptance: in IDLE with lsu_req_i=1, latch address, type, we, data and tag into internal registers.
- Alignment check (combinational):
  - half: addr[0]=0
  - word: addr[1:0]=0
  - cap: addr[2:0]=0 if CHECK_CAP_ALIGN, else addr[1:0]=0
- Misaligned access: no bus request; next state FAULT. FAULT emits lsu_valid_o=1 and lsu_misaligned_o=1 for one cycle, then returns to IDLE.
- Aligned access, first beat:
  - data_req_o asserts combinationally in the same cycle as lsu_req_i.
  - data_addr_o = {addr[31:2],2'b00}.
  - If data_gnt_i is also 1 that cycle, go to RVALID0; otherwise go to GNT0.
  - After IDLE, all bus outputs come from the latched registers and are held stable until grant.
- GNT0: data_req_o=1; on data_gnt_i go to RVALID0.
- RVALID0, on data_rvalid_i:
  - Non-cap access, or any data_err_i: pulse lsu_valid_o; lsu_err_o=data_err_i; go to IDLE. An error on beat 0 suppresses beat 1.
  - Cap access without error: store the low word and tag0; go to GNT1. The second request (address +4) is issued the following cycle.
- Back-to-back: no second outstanding transaction; rvalid and a new request never overlap. A new lsu_req_i is sampled no earlier than the cycle after lsu_valid_o.
- GNT1: data_req_o=1; on data_gnt_i go to RVALID1.
- RVALID1, on data_rvalid_i:
  - lsu_cap_rdata_o={rdata1,rdata0}
  - lsu_cap_rtag_o = tag0 & data_rtag_i & ~data_err_i
  - pulse lsu_valid_o; lsu_err_o=data_err_i; go to IDLE.
- Store data:
  - Byte: data_wdata_o = wdata replicated per lane; data_be_o = 0001<<addr[1:0].
  - Half: data_be_o = 0011<<addr[1:0].
  - Word and cap: data_be_o=1111.
  - Cap beat0 = cap_wdata[31:0], beat1 = cap_wdata[63:32].
  - data_wtag_o = cap_wtag on both cap beats; 0 on every non-cap store, so an integer store clears the memory tag.
- Load data: shift by addr[1:0], then zero/sign-extend per lsu_sign_ext_i. lsu_rdata_o and lsu_cap_* are registered and hold until the next completion.
- Pulses: lsu_valid_o is exactly one cycle per accepted request (including faults). data_rvalid_i outside RVALID0/RVALID1 is ignored.

Test Plan:
- Word load, gnt same cycle, rvalid +1, addr 0x1000, rdata 0xDEADBEEF -> data_req_o in cycle 0; lsu_valid_o in cycle 2; lsu_rdata_o=0xDEADBEEF; err=0.
- Signed byte load, addr 0x1003, rdata 0x80FF_FF00 -> data_be_o=1000; lsu_rdata_o=0xFFFFFF80. Unsigned -> 0x00000080.
- Cap store, addr 0x2000, cap 0x1122334455667788, tag=1, gnt delayed 2 cycles on each beat:
  - beat0: addr 0x2000, wdata 0x55667788, wtag 1
  - beat1: addr 0x2004, wdata 0x11223344, wtag 1
  - single lsu_valid_o after the second rvalid.
- Cap load, addr 0x3000, beat0 rtag=1, beat1 rtag=0 -> lsu_cap_rtag_o=0, cap data concatenated. Same with both rtag=1 -> tag 1.
- Cap load, addr 0x3004 (CHECK_CAP_ALIGN=1) -> no data_req_o; lsu_valid_o and lsu_misaligned_o one cycle later.
- Cap load with data_err_i on beat0 -> no second request; lsu_err_o=1, lsu_cap_rtag_o=0.
- Reset asserted in GNT1 -> data_req_o=0 immediately; no lsu_valid_o; next request completes normally.

Source files
------------

// File: rtl/ibex_cheri_cap_lsu.sv
// Load/store unit for the CHERI Ibex core: scalar byte/half/word accesses
// and two-beat tagged capability accesses on the req/gnt/rvalid data bus.
module ibex_cheri_cap_lsu #(
    parameter int unsigned CAP_MEM_W       = 64,
    parameter bit          CHECK_CAP_ALIGN = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 lsu_req_i,
    input  logic                 lsu_we_i,
    input  logic                 lsu_cap_i,
    input  logic [1:0]           lsu_type_i,
    input  logic                 lsu_sign_ext_i,
    input  logic [31:0]          lsu_addr_i,
    input  logic [31:0]          lsu_wdata_i,
    input  logic [CAP_MEM_W-1:0] lsu_cap_wdata_i,
    input  logic                 lsu_cap_wtag_i,
    output logic [31:0]          lsu_rdata_o,
    output logic [CAP_MEM_W-1:0] lsu_cap_rdata_o,
    output logic                 lsu_cap_rtag_o,
    output logic                 lsu_valid_o,
    output logic                 lsu_err_o,
    output logic                 lsu_misaligned_o,
    output logic                 lsu_busy_o,
    output logic                 data_req_o,
    input  logic                 data_gnt_i,
    input  logic                 data_rvalid_i,
    input  logic                 data_err_i,
    output logic [31:0]          data_addr_o,
    output logic                 data_we_o,
    output logic [3:0]           data_be_o,
    output logic [31:0]          data_wdata_o,
    output logic                 data_wtag_o,
    input  logic [31:0]          data_rdata_i,
    input  logic                 data_rtag_i
);

    typedef enum logic [2:0] {
        IDLE,
        GNT0,
        RVALID0,
        GNT1,
        RVALID1,
        FAULT
    } state_e;

    localparam logic [1:0] TYPE_H = 2'b01;
    localparam logic [1:0] TYPE_B = 2'b10;

    state_e state_q, state_d;

    logic [31:0]          addr_q;
    logic [1:0]           type_q;
    logic                 we_q;
    logic                 cap_q;
    logic                 sext_q;
    logic [31:0]          wdata_q;
    logic [CAP_MEM_W-1:0] cap_wdata_q;
    logic                 cap_wtag_q;

    logic [31:0]          rdata0_q;
    logic                 tag0_q;
    logic [31:0]          rdata_q;
    logic [CAP_MEM_W-1:0] cap_rdata_q;
    logic                 cap_rtag_q;
    logic                 valid_q;
    logic                 err_q;

    logic                 idle;
    logic                 accept;
    logic                 misaligned;
    logic                 beat1;
    logic                 done0;
    logic                 done1;
    logic                 beat0_ok;

    logic [31:0]          cur_addr;
    logic [1:0]           cur_type;
    logic                 cur_we;
    logic                 cur_cap;
    logic [31:0]          cur_wdata;
    logic [CAP_MEM_W-1:0] cur_cap_wdata;
    logic                 cur_wtag;

    assign idle   = (state_q == IDLE);
    assign accept = idle & lsu_req_i;
    assign beat1  = (state_q == GNT1);

    // While idle the first beat is driven straight from the EX inputs;
    // afterwards everything comes from the latched request.
    assign cur_addr      = idle ? lsu_addr_i      : addr_q;
    assign cur_type      = idle ? lsu_type_i      : type_q;
    assign cur_we        = idle ? lsu_we_i        : we_q;
    assign cur_cap       = idle ? lsu_cap_i       : cap_q;
    assign cur_wdata     = idle ? lsu_wdata_i     : wdata_q;
    assign cur_cap_wdata = idle ? lsu_cap_wdata_i : cap_wdata_q;
    assign cur_wtag      = idle ? lsu_cap_wtag_i  : cap_wtag_q;

    always_comb begin
        misaligned = 1'b0;
        if (lsu_cap_i) begin
            if (CHECK_CAP_ALIGN) begin
                misaligned = |lsu_addr_i[2:0];
            end else begin
                misaligned = |lsu_addr_i[1:0];
            end
        end else begin
            case (lsu_type_i)
                TYPE_H:  misaligned = lsu_addr_i[0];
                TYPE_B:  misaligned = 1'b0;
                default: misaligned = |lsu_addr_i[1:0];
            endcase
        end
    end

    assign data_req_o = (accept & ~misaligned)
                      | (state_q == GNT0)
                      | beat1;

    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;

    always_comb begin
        bus_addr  = {cur_addr[31:2], 2'b00};
        bus_be    = 4'b1111;
        bus_wdata = cur_wdata;
        if (beat1) begin
            bus_addr = bus_addr + 32'd4;
        end
        if (cur_cap) begin
            bus_wdata = beat1 ? cur_cap_wdata[63:32] : cur_cap_wdata[31:0];
        end else begin
            case (cur_type)
                TYPE_H: begin
                    bus_be    = 4'b0011 << cur_addr[1:0];
                    bus_wdata = {2{cur_wdata[15:0]}};
                end
                TYPE_B: begin
                    bus_be    = 4'b0001 << cur_addr[1:0];
                    bus_wdata = {4{cur_wdata[7:0]}};
                end
                default: ;
            endcase
        end
    end

    // Bus outputs are forced to zero whenever no request is pending.
    assign data_addr_o  = data_req_o ? bus_addr  : 32'h0;
    assign data_be_o    = data_req_o ? bus_be    : 4'h0;
    assign data_wdata_o = data_req_o ? bus_wdata : 32'h0;
    assign data_we_o    = data_req_o & cur_we;
    assign data_wtag_o  = data_req_o & cur_cap & cur_we & cur_wtag;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (lsu_req_i) begin
                    if (misaligned) begin
                        state_d = FAULT;
                    end else if (data_gnt_i) begin
                        state_d = RVALID0;
                    end else begin
                        state_d = GNT0;
                    end
                end
            end
            GNT0: begin
                if (data_gnt_i) state_d = RVALID0;
            end
            RVALID0: begin
                if (data_rvalid_i) begin
                    state_d = (cap_q & ~data_err_i) ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (data_gnt_i) state_d = RVALID1;
            end
            RVALID1: begin
                if (data_rvalid_i) state_d = IDLE;
            end
            FAULT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign done0    = (state_q == RVALID0) & data_rvalid_i
                    & (~cap_q | data_err_i);
    assign beat0_ok = (state_q == RVALID0) & data_rvalid_i
                    & cap_q & ~data_err_i;
    assign done1    = (state_q == RVALID1) & data_rvalid_i;

    function automatic logic [31:0] align_load(
        input logic [31:0] d,
        input logic [1:0]  off,
        input logic [1:0]  t,
        input logic        sx
    );
        logic [31:0] s;
        s = d >> {off, 3'b000};
        case (t)
            TYPE_H:  align_load = {{16{sx & s[15]}}, s[15:0]};
            TYPE_B:  align_load = {{24{sx & s[7]}}, s[7:0]};
            default: align_load = s;
        endcase
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            type_q      <= '0;
            we_q        <= 1'b0;
            cap_q       <= 1'b0;
            sext_q      <= 1'b0;
            wdata_q     <= '0;
            cap_wdata_q <= '0;
            cap_wtag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q      <= lsu_addr_i;
                type_q      <= lsu_type_i;
                we_q        <= lsu_we_i;
                cap_q       <= lsu_cap_i;
                sext_q      <= lsu_sign_ext_i;
                wdata_q     <= lsu_wdata_i;
                cap_wdata_q <= lsu_cap_wdata_i;
                cap_wtag_q  <= lsu_cap_wtag_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata0_q    <= '0;
            tag0_q      <= 1'b0;
            rdata_q     <= '0;
            cap_rdata_q <= '0;
            cap_rtag_q  <= 1'b0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            valid_q <= done0 | done1;
            err_q   <= (done0 | done1) & data_err_i;
            if (done0 & ~cap_q & ~we_q) begin
                rdata_q <= align_load(data_rdata_i, addr_q[1:0],
                                      type_q, sext_q);
            end
            // A faulting first beat invalidates any previously loaded tag.
            if (done0 & cap_q) begin
                cap_rtag_q <= 1'b0;
            end
            if (beat0_ok) begin
                rdata0_q <= data_rdata_i;
                tag0_q   <= data_rtag_i;
            end
            if (done1 & ~we_q) begin
                cap_rdata_q <= {data_rdata_i, rdata0_q};
                cap_rtag_q  <= tag0_q & data_rtag_i & ~data_err_i;
            end
        end
    end

    assign lsu_valid_o      = valid_q | (state_q == FAULT);
    assign lsu_err_o        = err_q;
    assign lsu_misaligned_o = (state_q == FAULT);
    assign lsu_busy_o       = ~idle;
    assign lsu_rdata_o      = rdata_q;
    assign lsu_cap_rdata_o  = cap_rdata_q;
    assign lsu_cap_rtag_o   = cap_rtag_q;

endmodule

// File: tb/tb_ibex_cheri_cap_lsu.sv
// Directed bench for ibex_cheri_cap_lsu: scalar and capability accesses,
// alignment faults, bus errors and reset abandonment.
module tb_ibex_cheri_cap_lsu;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        lsu_req_i = 1'b0;
    logic        lsu_we_i = 1'b0;
    logic        lsu_cap_i = 1'b0;
    logic [1:0]  lsu_type_i = 2'b00;
    logic        lsu_sign_ext_i = 1'b0;
    logic [31:0] lsu_addr_i = '0;
    logic [31:0] lsu_wdata_i = '0;
    logic [63:0] lsu_cap_wdata_i = '0;
    logic        lsu_cap_wtag_i = 1'b0;
    logic [31:0] lsu_rdata_o;
    logic [63:0] lsu_cap_rdata_o;
    logic        lsu_cap_rtag_o;
    logic        lsu_valid_o;
    logic        lsu_err_o;
    logic        lsu_misaligned_o;
    logic        lsu_busy_o;
    logic        data_req_o;
    logic        data_gnt_i = 1'b0;
    logic        data_rvalid_i = 1'b0;
    logic        data_err_i = 1'b0;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_wtag_o;
    logic [31:0] data_rdata_i = '0;
    logic        data_rtag_i = 1'b0;

    int n_run = 0;
    int n_fail = 0;

    ibex_cheri_cap_lsu #(
        .CAP_MEM_W(64),
        .CHECK_CAP_ALIGN(1'b1)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .lsu_req_i(lsu_req_i),
        .lsu_we_i(lsu_we_i),
        .lsu_cap_i(lsu_cap_i),
        .lsu_type_i(lsu_type_i),
        .lsu_sign_ext_i(lsu_sign_ext_i),
        .lsu_addr_i(lsu_addr_i),
        .lsu_wdata_i(lsu_wdata_i),
        .lsu_cap_wdata_i(lsu_cap_wdata_i),
        .lsu_cap_wtag_i(lsu_cap_wtag_i),
        .lsu_rdata_o(lsu_rdata_o),
        .lsu_cap_rdata_o(lsu_cap_rdata_o),
        .lsu_cap_rtag_o(lsu_cap_rtag_o),
        .lsu_valid_o(lsu_valid_o),
        .lsu_err_o(lsu_err_o),
        .lsu_misaligned_o(lsu_misaligned_o),
        .lsu_busy_o(lsu_busy_o),
        .data_req_o(data_req_o),
        .data_gnt_i(data_gnt_i),
        .data_rvalid_i(data_rvalid_i),
        .data_err_i(data_err_i),
        .data_addr_o(data_addr_o),
        .data_we_o(data_we_o),
        .data_be_o(data_be_o),
        .data_wdata_o(data_wdata_o),
        .data_wtag_o(data_wtag_o),
        .data_rdata_i(data_rdata_i),
        .data_rtag_i(data_rtag_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Single-beat access: grant in the request cycle, rvalid one cycle later.
    task automatic simple_access(
        input string       tag,
        input logic        we,
        input logic [1:0]  t,
        input logic        sx,
        input logic [31:0] a,
        input logic [31:0] wd,
        input logic [31:0] rd,
        input logic [3:0]  exp_be,
        input logic [31:0] exp_wdata,
        input logic [31:0] exp_rdata
    );
        tick();
        lsu_req_i = 1'b1; lsu_we_i = we; lsu_cap_i = 1'b0;
        lsu_type_i = t; lsu_sign_ext_i = sx; lsu_addr_i = a;
        lsu_wdata_i = wd; data_gnt_i = 1'b1;
        #1;
        chk({tag, " req"}, 64'(data_req_o), 64'd1);
        chk({tag, " addr"}, 64'(data_addr_o), 64'({a[31:2], 2'b00}));
        chk({tag, " be"}, 64'(data_be_o), 64'(exp_be));
        chk({tag, " we"}, 64'(data_we_o), 64'(we));
        chk({tag, " wdata"}, 64'(data_wdata_o), 64'(exp_wdata));
        chk({tag, " wtag"}, 64'(data_wtag_o), 64'd0);
        tick();
        lsu_req_i = 1'b0; data_gnt_i = 1'b0;
        data_rvalid_i = 1'b1; data_rdata_i = rd;
        #1;
        chk({tag, " early valid"}, 64'(lsu_valid_o), 64'd0);
        tick();
        data_rvalid_i = 1'b0;
        #1;
        chk({tag, " valid"}, 64'(lsu_valid_o), 64'd1);
        chk({tag, " err"}, 64'(lsu_err_o), 64'd0);
        if (!we) chk({tag, " rdata"}, 64'(lsu_rdata_o), 64'(exp_rdata));
        tick();
        chk({tag, " valid pulse"}, 64'(lsu_valid_o), 64'd0);
        if (!we) chk({tag, " rdata hold"}, 64'(lsu_rdata_o), 64'(exp_rdata));
    endtask

    // Capability load with immediate grants and no bus error.
    task automatic cap_load(
        input string       tag,
        input logic [31:0] a,
        input logic [31:0] r0,
        input logic        t0,
        input logic [31:0] r1,
        input logic        t1,
        input logic        exp_tag
    );
        tick();
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_cap_i = 1'b1;
        lsu_addr_i = a; data_gnt_i = 1'b1;
        #1;
        chk({tag, " b0 addr"}, 64'(data_addr_o), 64'(a));
        tick();
        lsu_req_i = 1'b0; data_gnt_i = 1'b0;
        data_rvalid_i = 1'b1; data_rdata_i = r0; data_rtag_i = t0;
        #1;
        chk({tag, " b0 no req"}, 64'(data_req_o), 64'd0);
        tick();
        data_rvalid_i = 1'b0;
        #1;
        chk({tag, " b1 req"}, 64'(data_req_o), 64'd1);
        chk({tag, " b1 addr"}, 64'(data_addr_o), 64'(a + 32'd4));
        chk({tag, " b1 we"}, 64'(data_we_o), 64'd0);
        chk({tag, " mid valid"}, 64'(lsu_valid_o), 64'd0);
        data_gnt_i = 1'b1;
        tick();
        data_gnt_i = 1'b0;
        data_rvalid_i = 1'b1; data_rdata_i = r1; data_rtag_i = t1;
        tick();
        data_rvalid_i = 1'b0; data_rtag_i = 1'b0;
        #1;
        chk({tag, " valid"}, 64'(lsu_valid_o), 64'd1);
        chk({tag, " err"}, 64'(lsu_err_o), 64'd0);
        chk({tag, " cap data"}, lsu_cap_rdata_o, {r1, r0});
        chk({tag, " cap tag"}, 64'(lsu_cap_rtag_o), 64'(exp_tag));
        tick();
        chk({tag, " valid pulse"}, 64'(lsu_valid_o), 64'd0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst req", 64'(data_req_o), 64'd0);
        chk("rst valid", 64'(lsu_valid_o), 64'd0);
        chk("rst busy", 64'(lsu_busy_o), 64'd0);
        chk("rst mis", 64'(lsu_misaligned_o), 64'd0);
        chk("rst err", 64'(lsu_err_o), 64'd0);
        chk("rst addr", 64'(data_addr_o), 64'd0);
        chk("rst be", 64'(data_be_o), 64'd0);
        chk("rst wdata", 64'(data_wdata_o), 64'd0);
        chk("rst rdata", 64'(lsu_rdata_o), 64'd0);
        chk("rst cap", lsu_cap_rdata_o, 64'd0);
        chk("rst ctag", 64'(lsu_cap_rtag_o), 64'd0);
        rst_ni = 1'b1;

        // Scalar accesses
        simple_access("lw", 1'b0, 2'b00, 1'b0, 32'h0000_1000, 32'h0,
                      32'hDEAD_BEEF, 4'b1111, 32'h0, 32'hDEAD_BEEF);
        simple_access("lb s", 1'b0, 2'b10, 1'b1, 32'h0000_1003, 32'h0,
                      32'h80FF_FF00, 4'b1000, 32'h0, 32'hFFFF_FF80);
        simple_access("lbu", 1'b0, 2'b10, 1'b0, 32'h0000_1003, 32'h0,
                      32'h80FF_FF00, 4'b1000, 32'h0, 32'h0000_0080);
        simple_access("lh s", 1'b0, 2'b01, 1'b1, 32'h0000_1002, 32'h0,
                      32'h8001_7FFF, 4'b1100, 32'h0, 32'hFFFF_8001);
        simple_access("lhu", 1'b0, 2'b01, 1'b0, 32'h0000_1000, 32'h0,
                      32'h8001_F234, 4'b0011, 32'h0, 32'h0000_F234);
        simple_access("sb", 1'b1, 2'b10, 1'b0, 32'h0000_1002,
                      32'h1234_56A5, 32'h0, 4'b0100, 32'hA5A5_A5A5, 32'h0);
        simple_access("sh", 1'b1, 2'b01, 1'b0, 32'h0000_1002,
                      32'hABCD_1234, 32'h0, 4'b1100, 32'h1234_1234, 32'h0);
        simple_access("sw rsvd", 1'b1, 2'b11, 1'b0, 32'h0000_1004,
                      32'hCAFE_F00D, 32'h0, 4'b1111, 32'hCAFE_F00D, 32'h0);

        // Capability store, grant delayed two cycles per beat
        tick();
        lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_cap_i = 1'b1;
        lsu_type_i = 2'b00; lsu_addr_i = 32'h0000_2000;
        lsu_cap_wdata_i = 64'h1122_3344_5566_7788; lsu_cap_wtag_i = 1'b1;
        #1;
        chk("cs b0 req", 64'(data_req_o), 64'd1);
        chk("cs b0 addr", 64'(data_addr_o), 64'h2000);
        chk("cs b0 wdata", 64'(data_wdata_o), 64'h5566_7788);
        chk("cs b0 wtag", 64'(data_wtag_o), 64'd1);
        chk("cs b0 be", 64'(data_be_o), 64'hF);
        tick();
        lsu_req_i = 1'b0; lsu_addr_i = 32'hFFFF_FFFF;
        lsu_cap_wdata_i = '0; lsu_cap_wtag_i = 1'b0;
        #1;
        chk("cs b0 hold addr", 64'(data_addr_o), 64'h2000);
        chk("cs b0 hold wdata", 64'(data_wdata_o), 64'h5566_7788);
        chk("cs busy", 64'(lsu_busy_o), 64'd1);
        tick();
        data_gnt_i = 1'b1;
        #1;
        chk("cs b0 gnt req", 64'(data_req_o), 64'd1);
        chk("cs b0 gnt wtag", 64'(data_wtag_o), 64'd1);
        tick();
        data_gnt_i = 1'b0; data_rvalid_i = 1'b1;
        #1;
        chk("cs rv0 req", 64'(data_req_o), 64'd0);
        tick();
        data_rvalid_i = 1'b0;
        #1;
        chk("cs b1 req", 64'(data_req_o), 64'd1);
        chk("cs b1 addr", 64'(data_addr_o), 64'h2004);
        chk("cs b1 wdata", 64'(data_wdata_o), 64'h1122_3344);
        chk("cs b1 wtag", 64'(data_wtag_o), 64'd1);
        chk("cs b1 we", 64'(data_we_o), 64'd1);
        chk("cs mid valid", 64'(lsu_valid_o), 64'd0);
        tick();
        tick();
        data_gnt_i = 1'b1;
        #1;
        chk("cs b1 gnt addr", 64'(data_addr_o), 64'h2004);
        tick();
        data_gnt_i = 1'b0; data_rvalid_i = 1'b1;
        #1;
        chk("cs rv1 valid", 64'(lsu_valid_o), 64'd0);
        tick();
        data_rvalid_i = 1'b0;
        #1;
        chk("cs valid", 64'(lsu_valid_o), 64'd1);
        chk("cs err", 64'(lsu_err_o), 64'd0);
        tick();
        chk("cs valid pulse", 64'(lsu_valid_o), 64'd0);

        // Capability loads: tag is the AND of both beat tags
        cap_load("cl t10", 32'h0000_3000, 32'hAAAA_0001, 1'b1,
                 32'hBBBB_0002, 1'b0, 1'b0);
        cap_load("cl t11", 32'h0000_3000, 32'h0123_4567, 1'b1,
                 32'h89AB_CDEF, 1'b1, 1'b1);

        // Misaligned capability load
        tick();
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_cap_i = 1'b1;
        lsu_addr_i = 32'h0000_3004;
        #1;
        chk("mis no req", 64'(data_req_o), 64'd0);
        chk("mis early valid", 64'(lsu_valid_o), 64'd0);
        tick();
        lsu_req_i = 1'b0;
        #1;
        chk("mis valid", 64'(lsu_valid_o), 64'd1);
        chk("mis flag", 64'(lsu_misaligned_o), 64'd1);
        chk("mis err", 64'(lsu_err_o), 64'd0);
        chk("mis req", 64'(data_req_o), 64'd0);
        tick();
        chk("mis pulse", 64'(lsu_valid_o), 64'd0);
        chk("mis flag pulse", 64'(lsu_misaligned_o), 64'd0);
        chk("mis busy", 64'(lsu_busy_o), 64'd0);

        // Misaligned halfword
        tick();
        lsu_req_i = 1'b1; lsu_cap_i = 1'b0; lsu_type_i = 2'b01;
        lsu_addr_i = 32'h0000_1001;
        #1;
        chk("mish no req", 64'(data_req_o), 64'd0);
        tick();
        lsu_req_i = 1'b0;
        #1;
        chk("mish flag", 64'(lsu_misaligned_o), 64'd1);
        tick();

        // Capability load with error on the first beat
        tick();
        lsu_req_i = 1'b1; lsu_cap_i = 1'b1; lsu_type_i = 2'b00;
        lsu_addr_i = 32'h0000_3000; data_gnt_i = 1'b1;
        tick();
        lsu_req_i = 1'b0; data_gnt_i = 1'b0;
        data_rvalid_i = 1'b1; data_err_i = 1'b1; data_rtag_i = 1'b1;
        tick();
        data_rvalid_i = 1'b0; data_err_i = 1'b0; data_rtag_i = 1'b0;
        #1;
        chk("clerr no b1", 64'(data_req_o), 64'd0);
        chk("clerr valid", 64'(lsu_valid_o), 64'd1);
        chk("clerr err", 64'(lsu_err_o), 64'd1);
        chk("clerr tag", 64'(lsu_cap_rtag_o), 64'd0);
        tick();
        chk("clerr idle req", 64'(data_req_o), 64'd0);
        chk("clerr pulse", 64'(lsu_valid_o), 64'd0);
        chk("clerr err clr", 64'(lsu_err_o), 64'd0);

        // Reset in GNT1 abandons the access
        tick();
        lsu_req_i = 1'b1; lsu_cap_i = 1'b1; lsu_addr_i = 32'h0000_3000;
        data_gnt_i = 1'b1;
        tick();
        lsu_req_i = 1'b0; data_gnt_i = 1'b0; data_rvalid_i = 1'b1;
        data_rtag_i = 1'b1;
        tick();
        data_rvalid_i = 1'b0; data_rtag_i = 1'b0;
        #1;
        chk("rst1 in gnt1", 64'(data_req_o), 64'd1);
        rst_ni = 1'b0;
        #1;
        chk("rst1 req", 64'(data_req_o), 64'd0);
        chk("rst1 busy", 64'(lsu_busy_o), 64'd0);
        data_gnt_i = 1'b1;
        tick();
        data_gnt_i = 1'b0; data_rvalid_i = 1'b1;
        chk("rst1 valid", 64'(lsu_valid_o), 64'd0);
        rst_ni = 1'b1;
        tick();
        #1;
        chk("rst1 late rvalid", 64'(lsu_valid_o), 64'd0);
        data_rvalid_i = 1'b0;
        tick();
        chk("rst1 late rvalid2", 64'(lsu_valid_o), 64'd0);
        lsu_cap_i = 1'b0;
        simple_access("post rst lw", 1'b0, 2'b00, 1'b0, 32'h0000_1008,
                      32'h0, 32'h0BAD_F00D, 4'b1111, 32'h0, 32'h0BAD_F00D);

        tick();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
